// File: rtl/piezo_tone_decoder.sv
// Square-wave tone decoder: measures the input period in clock cycles and
// locks to the matching one-hot note code (bit 0 = C4 ... bit 7 = C5).
module piezo_tone_decoder #(
    parameter int LOCK_CNT = 2,
    parameter int TIMEOUT  = 8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        piezo_in,
    output logic [7:0]  note,
    output logic        valid,
    output logic [12:0] period
);

    localparam logic [2:0]  LOCK_N  = 3'(LOCK_CNT);
    localparam logic [12:0] CNT_MAX = 13'd8191;
    localparam logic [12:0] TO_LAST = 13'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;

    state_t      state, state_nxt;
    logic        s1, s2, s3;
    logic        rise;
    logic [12:0] cnt;
    logic [13:0] p_wide;
    logic        hit;
    logic [2:0]  k;
    logic [2:0]  match_cnt, match_cnt_nxt;
    logic [2:0]  cand, cand_nxt;
    logic [2:0]  acq_next;
    logic [7:0]  note_nxt;
    logic        valid_nxt;
    logic        timeout;

    function automatic logic [12:0] sat_inc(input logic [12:0] v);
        return (v == CNT_MAX) ? v : v + 13'd1;
    endfunction

    // A saturated counter yields 8192, which is clamped rather than wrapped to 0.
    function automatic logic [12:0] sat_period(input logic [13:0] v);
        return v[13] ? CNT_MAX : v[12:0];
    endfunction

    // Returns {hit, note index}; bands are contiguous from 1800 to 4000.
    function automatic logic [3:0] classify(input logic [13:0] p);
        if (p < 14'd1800 || p > 14'd4000) return 4'b0_000;
        else if (p >= 14'd3609)           return 4'b1_000;
        else if (p >= 14'd3216)           return 4'b1_001;
        else if (p >= 14'd2948)           return 4'b1_010;
        else if (p >= 14'd2708)           return 4'b1_011;
        else if (p >= 14'd2412)           return 4'b1_100;
        else if (p >= 14'd2149)           return 4'b1_101;
        else if (p >= 14'd1968)           return 4'b1_110;
        else                              return 4'b1_111;
    endfunction

    function automatic logic [7:0] onehot(input logic [2:0] i);
        return 8'b1 << i;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= piezo_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise     = s2 & ~s3;
    assign p_wide   = {1'b0, cnt} + 14'd1;
    assign {hit, k} = classify(p_wide);
    assign acq_next = (k == cand) ? match_cnt + 3'd1 : 3'd1;
    assign timeout  = !rise && (cnt == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            period <= '0;
        end else if (rise) begin
            cnt    <= '0;
            period <= sat_period(p_wide);
        end else begin
            cnt    <= sat_inc(cnt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            match_cnt <= '0;
            cand      <= '0;
            note      <= '0;
            valid     <= 1'b0;
        end else begin
            state     <= state_nxt;
            match_cnt <= match_cnt_nxt;
            cand      <= cand_nxt;
            note      <= note_nxt;
            valid     <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        match_cnt_nxt = match_cnt;
        cand_nxt      = cand;
        note_nxt      = note;
        valid_nxt     = valid;
        case (state)
            IDLE: begin
                // The first edge after silence only starts the period measurement.
                if (rise) begin
                    state_nxt     = ACQ;
                    match_cnt_nxt = '0;
                end
            end
            ACQ: begin
                if (rise) begin
                    if (!hit) begin
                        match_cnt_nxt = '0;
                    end else begin
                        cand_nxt      = k;
                        match_cnt_nxt = acq_next;
                        if (acq_next >= LOCK_N) begin
                            state_nxt = LOCK;
                            note_nxt  = onehot(k);
                            valid_nxt = 1'b1;
                        end
                    end
                end else if (timeout) begin
                    state_nxt     = IDLE;
                    match_cnt_nxt = '0;
                    note_nxt      = '0;
                    valid_nxt     = 1'b0;
                end
            end
            LOCK: begin
                if (rise) begin
                    if (!hit) begin
                        state_nxt     = ACQ;
                        match_cnt_nxt = '0;
                        note_nxt      = '0;
                        valid_nxt     = 1'b0;
                    end else if (onehot(k) != note) begin
                        cand_nxt      = k;
                        match_cnt_nxt = 3'd1;
                        if (LOCK_N == 3'd1) begin
                            note_nxt  = onehot(k);
                        end else begin
                            state_nxt = ACQ;
                            note_nxt  = '0;
                            valid_nxt = 1'b0;
                        end
                    end
                end else if (timeout) begin
                    state_nxt     = IDLE;
                    match_cnt_nxt = '0;
                    note_nxt      = '0;
                    valid_nxt     = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_piezo_tone_decoder.sv
// Bench for piezo_tone_decoder: table-driven tone segments, hand sequences for
// reset and timeout, random tones, and a per-cycle behavioural reference model.
`timescale 1ns/1ps
module tb_piezo_tone_decoder;

    localparam int LOCK_CNT = 2;
    localparam int TIMEOUT  = 5000;

    logic        clk;
    logic        rst;
    logic        piezo_in;
    logic [7:0]  note;
    logic        valid;
    logic [12:0] period;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_rise = 0;
    bit mon_en = 0;

    piezo_tone_decoder #(.LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .piezo_in(piezo_in),
        .note(note),
        .valid(valid),
        .period(period)
    );

    initial clk = 1'b0;
    always #500 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: works from the time of each input rise (effective two
    // clocks after it is first sampled) and the distance between effective rises.
    localparam int M_IDLE = 0, M_ACQ = 1, M_LOCK = 2;
    int          band_lo [8] = '{3609, 3216, 2948, 2708, 2412, 2149, 1968, 1800};
    int          band_hi [8] = '{4000, 3608, 3215, 2947, 2707, 2411, 2148, 1967};
    int          e_idx = 0;
    int          last_e = 0;
    int          m_state = M_IDLE;
    int          m_mc = 0;
    int          m_cand = 0;
    logic [7:0]  m_note = '0;
    logic        m_valid = 1'b0;
    logic [12:0] m_period = '0;
    bit          prev_s = 0;
    int          pend[$];

    function automatic int band(input int p);
        for (int b = 0; b < 8; b++)
            if (p >= band_lo[b] && p <= band_hi[b]) return b;
        return -1;
    endfunction

    always @(posedge clk) begin
        int p;
        int kk;
        bit ev;
        e_idx++;
        if (rst) begin
            m_state = M_IDLE; m_mc = 0; m_cand = 0;
            m_note = '0; m_valid = 1'b0; m_period = '0;
            prev_s = 0; last_e = e_idx;
            pend.delete();
        end else begin
            ev = (pend.size() > 0 && pend[0] == e_idx);
            if (ev) void'(pend.pop_front());
            if (piezo_in && !prev_s) pend.push_back(e_idx + 2);
            prev_s = piezo_in;
            if (ev) begin
                p = e_idx - last_e;
                last_e = e_idx;
                m_period = (p > 8191) ? 13'd8191 : 13'(p);
                kk = band(p);
                if (m_state == M_IDLE) begin
                    m_state = M_ACQ; m_mc = 0;
                end else if (m_state == M_ACQ) begin
                    if (kk < 0) m_mc = 0;
                    else begin
                        if (kk == m_cand) m_mc++;
                        else begin m_cand = kk; m_mc = 1; end
                        if (m_mc >= LOCK_CNT) begin
                            m_state = M_LOCK; m_note = 8'(1 << kk); m_valid = 1'b1;
                        end
                    end
                end else begin
                    if (kk < 0) begin
                        m_state = M_ACQ; m_mc = 0; m_note = '0; m_valid = 1'b0;
                    end else if (8'(1 << kk) != m_note) begin
                        m_cand = kk; m_mc = 1;
                        if (LOCK_CNT == 1) m_note = 8'(1 << kk);
                        else begin m_state = M_ACQ; m_note = '0; m_valid = 1'b0; end
                    end
                end
            end else if (m_state != M_IDLE && (e_idx - last_e) == TIMEOUT) begin
                m_state = M_IDLE; m_mc = 0; m_note = '0; m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (note !== m_note || valid !== m_valid || period !== m_period) begin
                errors++;
                $display("FAIL model @cycle %0d: got note=%h valid=%b period=%0d, expected note=%h valid=%b period=%0d",
                         cyc, note, valid, period, m_note, m_valid, m_period);
            end
        end
    end

    task automatic check3(input string name, input logic [7:0] n_exp, input logic v_exp,
                          input logic [12:0] p_exp);
        checks++;
        if (note !== n_exp || valid !== v_exp || period !== p_exp) begin
            errors++;
            $display("FAIL %s: got note=%h valid=%b period=%0d, expected note=%h valid=%b period=%0d",
                     name, note, valid, period, n_exp, v_exp, p_exp);
        end
    endtask

    // Called at a falling clock edge; each period starts with the rising input.
    task automatic wave(input int t, input int hi, input int n);
        for (int i = 0; i < n; i++) begin
            piezo_in  = 1'b1;
            last_rise = cyc + 1;
            repeat (hi) @(negedge clk);
            piezo_in  = 1'b0;
            repeat (t - hi) @(negedge clk);
        end
    endtask

    typedef struct {
        int          t;
        int          n;
        logic [7:0]  note;
        logic        valid;
        logic [12:0] period;
    } row_t;

    row_t rows [10];

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            wave(rows[i].t, rows[i].t / 2, rows[i].n);
            check3($sformatf("row%0d_T%0d", i, rows[i].t), rows[i].note, rows[i].valid, rows[i].period);
        end
    endtask

    initial begin
        int t;
        int h;
        rows[0] = '{2273, 3, 8'h20, 1'b1, 13'd2273};  // A4 lock
        rows[1] = '{3401, 2, 8'h00, 1'b0, 13'd3401};  // first D4 period drops lock
        rows[2] = '{3401, 1, 8'h02, 1'b1, 13'd3401};  // D4 lock
        rows[3] = '{1799, 2, 8'h00, 1'b0, 13'd1799};  // below band
        rows[4] = '{4001, 2, 8'h00, 1'b0, 13'd4001};  // above band
        rows[5] = '{1800, 3, 8'h80, 1'b1, 13'd1800};  // lower edge -> C5
        rows[6] = '{3608, 3, 8'h02, 1'b1, 13'd3608};  // 3608 -> D4
        rows[7] = '{3609, 2, 8'h00, 1'b0, 13'd3609};  // 3609 is not D4
        rows[8] = '{4000, 1, 8'h01, 1'b1, 13'd3609};  // 3609 counted as C4 -> lock
        rows[9] = '{4000, 1, 8'h01, 1'b1, 13'd4000};  // 4000 keeps C4 lock

        rst = 1'b1;
        piezo_in = 1'b0;
        @(negedge clk);
        mon_en = 1;
        for (int i = 0; i < 6; i++) begin
            piezo_in = ~piezo_in;
            @(negedge clk);
            check3("reset_hold", 8'h00, 1'b0, 13'd0);
        end
        piezo_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10000) @(negedge clk);
        check3("silence", 8'h00, 1'b0, 13'd0);

        run_rows(0, 5);

        // Asynchronous reset pulse while locked on C5
        #3 rst = 1'b1;
        #1 check3("async_reset", 8'h00, 1'b0, 13'd0);
        @(negedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        wave(1912, 956, 2);
        check3("relock_acq", 8'h00, 1'b0, 13'd1912);
        wave(1912, 956, 1);
        check3("relock_c5", 8'h80, 1'b1, 13'd1912);

        run_rows(6, 9);

        // Silence while locked: drop exactly TIMEOUT cycles after the last edge update
        while (cyc < last_rise + 2 + TIMEOUT - 1) @(negedge clk);
        check3("pre_timeout", 8'h01, 1'b1, 13'd4000);
        @(negedge clk);
        check3("timeout", 8'h00, 1'b0, 13'd4000);

        for (int i = 0; i < 3; i++) begin
            t = $urandom_range(2250, 1750);
            h = $urandom_range(t - 1, 1);
            wave(t, h, 1);
        end
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
